// File: rtl/dff_bank_toggle_mon.sv
// D flip-flop bank with enable/sync clear and a per-edge toggle (Hamming distance) monitor.
// A small FSM accumulates toggles over a 2**WIN_LOG2-edge window and holds the result until accepted.
//
// state   | meaning
// IDLE    | waiting for start; last window result retained
// MEASURE | accumulating hd_nxt for N edges after the start edge
// HOLD    | result valid, waiting for win_ready
module dff_bank_toggle_mon #(
  parameter int               WIDTH    = 8,
  parameter int               CNT_W    = 16,
  parameter int               WIN_LOG2 = 4,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  localparam int              HDW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             srst,
  output logic [WIDTH-1:0] q,
  output logic [HDW-1:0]   hd_now,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] win_sum,
  output logic             win_sat,
  output logic             win_valid,
  input  logic             win_ready
);

  // Sum is evaluated one bit wider than its widest operand so the clip is detectable.
  localparam int SW = ((CNT_W > HDW) ? CNT_W : HDW) + 1;
  localparam logic [SW-1:0] SUM_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t              state;
  logic [WIN_LOG2-1:0] cnt;
  logic [WIDTH-1:0]    q_nxt;
  logic [WIDTH-1:0]    diff;
  logic [HDW-1:0]      hd_nxt;
  logic [SW-1:0]       sum_ext;
  logic                sum_clip;
  logic [CNT_W-1:0]    sum_sat;
  logic                cnt_last;

  always_comb begin
    q_nxt = srst ? RST_VAL : (en ? d : q);
    diff  = q ^ q_nxt;
  end

  always_comb begin
    hd_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hd_nxt = hd_nxt + HDW'(diff[i]);
    end
  end

  always_comb begin
    sum_ext  = SW'(win_sum) + SW'(hd_nxt);
    sum_clip = (sum_ext > SUM_MAX);
    sum_sat  = sum_clip ? {CNT_W{1'b1}} : sum_ext[CNT_W-1:0];
    cnt_last = (cnt == {WIN_LOG2{1'b1}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= RST_VAL;
      hd_now <= '0;
    end else begin
      q      <= q_nxt;
      hd_now <= hd_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      win_valid <= 1'b0;
      win_sum   <= '0;
      win_sat   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= MEASURE;
            busy    <= 1'b1;
            win_sum <= '0;
            win_sat <= 1'b0;
            cnt     <= '0;
          end
        end
        MEASURE: begin
          win_sum <= sum_sat;
          if (sum_clip) win_sat <= 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt_last) begin
            state     <= HOLD;
            win_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (win_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            win_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          win_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_toggle_mon.sv
// Directed bench for dff_bank_toggle_mon: a wide-accumulator instance (a) and a
// 4-bit saturating instance (b) share the same stimulus.
module tb_dff_bank_toggle_mon;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d = '0;
  logic       en = 1'b0;
  logic       srst = 1'b0;
  logic       start = 1'b0;
  logic       win_ready = 1'b0;

  logic [7:0]  qa, qb;
  logic [3:0]  hda, hdb;
  logic        busya, busyb, sata, satb, vala, valb;
  logic [15:0] suma;
  logic [3:0]  sumb;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dff_bank_toggle_mon #(.WIDTH(8), .CNT_W(16), .WIN_LOG2(2), .RST_VAL(8'hA5)) dut_a (
    .clk(clk), .rst_n(rst_n), .d(d), .en(en), .srst(srst), .q(qa), .hd_now(hda),
    .start(start), .busy(busya), .win_sum(suma), .win_sat(sata), .win_valid(vala),
    .win_ready(win_ready)
  );

  dff_bank_toggle_mon #(.WIDTH(8), .CNT_W(4), .WIN_LOG2(2), .RST_VAL(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .d(d), .en(en), .srst(srst), .q(qb), .hd_now(hdb),
    .start(start), .busy(busyb), .win_sum(sumb), .win_sat(satb), .win_valid(valb),
    .win_ready(win_ready)
  );

  typedef struct {
    logic       en;
    logic       srst;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic [3:0] exp_hd;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one window: start edge, then four loads alternating between v0 and v1.
  task automatic run_window(input logic [7:0] v0, input logic [7:0] v1);
    start = 1'b1; en = 1'b0;
    tick();
    chk("start_busy", busya, 1);
    chk("start_clear_sum", suma, 0);
    start = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = (i % 2 == 0) ? v0 : v1;
      tick();
      if (i < 3) chk("win_not_valid_early", vala, 0);
    end
    en = 1'b0;
    chk("win_valid_a", vala, 1);
    chk("win_valid_b", valb, 1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 4'd4};
    vecs[1] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 4'd8};
    vecs[2] = '{1'b1, 1'b0, 8'h0F, 8'h0F, 4'd4};
    vecs[3] = '{1'b0, 1'b0, 8'h33, 8'h0F, 4'd0};
    vecs[4] = '{1'b1, 1'b1, 8'hFF, 8'hA5, 4'd4};
    vecs[5] = '{1'b1, 1'b0, 8'hA5, 8'hA5, 4'd0};
    vecs[6] = '{1'b1, 1'b0, 8'h5A, 8'h5A, 4'd8};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 8'hA5, 4'd8};

    // Reset state, then an asynchronous mid-cycle reset pulse
    #12;
    chk("rst_q_a", qa, 8'hA5);
    chk("rst_q_b", qb, 8'h00);
    chk("rst_hd", hda, 0);
    chk("rst_busy", busya, 0);
    chk("rst_valid", vala, 0);
    chk("rst_sum", suma, 0);
    chk("rst_sat", sata, 0);
    rst_n = 1'b1;
    en = 1'b1; d = 8'h3C;
    tick();
    chk("load_3c", qa, 8'h3C);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_q", qa, 8'hA5);
    chk("async_rst_hd", hda, 0);
    #2 rst_n = 1'b1;
    en = 1'b0;
    tick();
    chk("post_rst_q", qa, 8'hA5);

    for (int i = 0; i < 8; i++) begin
      en = vecs[i].en; srst = vecs[i].srst; d = vecs[i].d;
      tick();
      chk($sformatf("vec%0d_q", i), qa, vecs[i].exp_q);
      chk($sformatf("vec%0d_hd", i), hda, vecs[i].exp_hd);
    end
    srst = 1'b0;

    // Window with 4 toggles per edge; b clips at 15
    en = 1'b1; d = 8'h00;
    tick();
    en = 1'b0;
    chk("idle_busy", busya, 0);
    run_window(8'h0F, 8'h00);
    chk("win1_sum_a", suma, 16);
    chk("win1_sat_a", sata, 0);
    chk("win1_sum_b", sumb, 15);
    chk("win1_sat_b", satb, 1);

    // Handshake: stall, start ignored in HOLD, activity doesn't disturb result
    win_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      en = 1'b1; d = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick();
      chk("hold_valid", vala, 1);
      chk("hold_sum", suma, 16);
    end
    en = 1'b0;
    start = 1'b1; win_ready = 1'b1;
    tick();
    chk("accept_busy", busya, 0);
    chk("accept_valid", vala, 0);
    chk("idle_retain_sum", suma, 16);
    start = 1'b0; win_ready = 1'b0;
    tick();
    chk("accept_start_ignored", busya, 0);

    // Window with 8 toggles per edge
    en = 1'b1; d = 8'h00;
    tick();
    run_window(8'hFF, 8'h00);
    chk("win2_sum_a", suma, 32);
    chk("win2_sat_a", sata, 0);
    chk("win2_sum_b", sumb, 15);
    chk("win2_sat_b", satb, 1);
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
    chk("win2_accept", vala, 0);

    // Reset in the middle of a window discards it
    start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1; d = 8'hFF;
    tick();
    d = 8'h00;
    tick();
    chk("mid_busy_pre", busya, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busya, 0);
    chk("mid_rst_sum", suma, 0);
    chk("mid_rst_valid", vala, 0);
    chk("mid_rst_q", qa, 8'hA5);
    #2 rst_n = 1'b1;
    en = 1'b0;
    tick();
    chk("mid_rst_stay_idle", busya, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
